// File: rtl/nios2_qsys_cpu_mul_pkg.sv
// Shared definitions for the W-stage multiply result block: op codes, FSM states, iteration count.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nios2_qsys_cpu_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
  localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

  // Width of the hi*hi iteration counter; holds up to 16 iterations.
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } mul_state_t;

  // Number of shift-add cycles for a 16-bit multiplier retiring radix bits per cycle.
  function automatic int mul_iter_count(input int radix);
    return 16 / radix;
  endfunction

endpackage

// File: rtl/nios2_qsys_cpu_mul_result_if.sv
// M-stage to W-stage multiply handshake: operands, partial products, result strobe.
// Latency: n/a (wiring only).
// Backpressure: M_ready from the slave stalls the master's M_valid offer.
interface nios2_qsys_cpu_mul_result_if;

  logic        M_valid;
  logic        M_ready;
  logic [1:0]  M_op;
  logic [31:0] M_src1;
  logic [31:0] M_src2;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic        W_mul_valid;
  logic [31:0] W_mul_result;
  logic        W_mul_busy;

  modport master (
    output M_valid, M_op, M_src1, M_src2, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  M_ready, W_mul_valid, W_mul_result, W_mul_busy
  );

  modport slave (
    input  M_valid, M_op, M_src1, M_src2, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output M_ready, W_mul_valid, W_mul_result, W_mul_busy
  );

endinterface

// File: rtl/nios2_qsys_cpu_mul_hh_iter.sv
// Unsigned 16x16 shift-add multiplier retiring RADIX (1, 2 or 4) multiplier bits per cycle.
// Latency: operands load on start; done is high during the last of 16/RADIX iteration cycles, hh valid after that edge.
// Backpressure: none; a start while running restarts the product.
import nios2_qsys_cpu_mul_pkg::*;

module nios2_qsys_cpu_mul_hh_iter #(
  parameter int RADIX = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [31:0] hh
);

  localparam int N = mul_iter_count(RADIX);

  logic [31:0]          mcand;
  logic [15:0]          mplier;
  logic [31:0]          acc;
  logic [MUL_CNT_W-1:0] cnt;
  logic                 run;
  logic [31:0]          partial;

  // Sum of the multiplicand shifted by each set bit in the current multiplier digit.
  always_comb begin
    partial = '0;
    for (int j = 0; j < RADIX; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  assign done = run && (cnt == MUL_CNT_W'(1));
  assign hh   = acc;

  // Load on start, then accumulate one digit per cycle until the counter runs out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= {16'b0, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= MUL_CNT_W'(N);
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc + partial;
      mcand  <= mcand << RADIX;
      mplier <= mplier >> RADIX;
      cnt    <= cnt - 1'b1;
      if (cnt == MUL_CNT_W'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_qsys_cpu_mul_result.sv
// W-stage multiply result: MUL low word from partial products, MULX* high word via hi*hi term plus signed correction.
// Latency: MUL result 1 cycle after acceptance; high-word ops 16/RADIX+2 cycles (2 with NIOS2_MUL_HH_DSP_EN defined).
// Backpressure: M_ready is low whenever the FSM is outside IDLE; offers during that time are ignored.
import nios2_qsys_cpu_mul_pkg::*;

module nios2_qsys_cpu_mul_result #(
  parameter int RADIX = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  nios2_qsys_cpu_mul_result_if.slave        bus
);

  mul_state_t  state;
  logic        mul_pend;
  logic        fin_phase;
  logic [1:0]  op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [31:0] p1_q;
  logic [31:0] p2_q;
  logic [31:0] p3_q;
  logic [31:0] hi_raw;
  logic [31:0] result_q;
  logic        valid_q;
  logic        busy_q;
  logic [31:0] hh;
  logic        hh_done;

  logic        accept;
  logic [32:0] mid;
  logic [32:0] low33;
  logic [31:0] hi_sum;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] hi_final;

  assign accept           = bus.M_valid && (state == IDLE);
  assign bus.M_ready      = (state == IDLE);
  assign bus.W_mul_valid  = valid_q;
  assign bus.W_mul_result = result_q;
  assign bus.W_mul_busy   = busy_q;

`ifdef NIOS2_MUL_HH_DSP_EN
  logic [31:0] hh_q;

  // Dedicated hi*hi multiplier registered in the capture cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hh_q <= '0;
    end else if (accept && (bus.M_op != MUL_OP_MUL)) begin
      hh_q <= {16'b0, bus.M_src1[31:16]} * {16'b0, bus.M_src2[31:16]};
    end
  end

  assign hh      = hh_q;
  assign hh_done = 1'b0;
`else
  nios2_qsys_cpu_mul_hh_iter #(
    .RADIX (RADIX)
  ) u_hh_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && (bus.M_op != MUL_OP_MUL)),
    .a       (bus.M_src1[31:16]),
    .b       (bus.M_src2[31:16]),
    .done    (hh_done),
    .hh      (hh)
  );
`endif

  // Product assembly: low word shared by MUL, its carry feeds the high word.
  always_comb begin
    mid      = {1'b0, p2_q} + {1'b0, p3_q};
    low33    = {1'b0, mid[15:0], 16'b0} + {1'b0, p1_q};
    hi_sum   = hh + {15'b0, mid[32:16]} + {31'b0, low33[32]};
    corr_a   = (op_q[1] && src1_q[31]) ? src2_q : 32'b0;
    corr_b   = ((op_q == MUL_OP_MULXSS) && src2_q[31]) ? src1_q : 32'b0;
    hi_final = hi_raw - corr_a - corr_b;
  end

  // Control FSM with registered result, strobe and busy; FINAL splits the 64-bit add from the correction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mul_pend  <= 1'b0;
      fin_phase <= 1'b0;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      hi_raw    <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      mul_pend <= 1'b0;
      if (mul_pend) begin
        result_q <= low33[31:0];
        valid_q  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.M_op;
            src1_q <= bus.M_src1;
            src2_q <= bus.M_src2;
            p1_q   <= bus.M_mul_cell_p1;
            p2_q   <= bus.M_mul_cell_p2;
            p3_q   <= bus.M_mul_cell_p3;
            if (bus.M_op == MUL_OP_MUL) begin
              mul_pend <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              fin_phase <= 1'b0;
`ifdef NIOS2_MUL_HH_DSP_EN
              state     <= FINAL;
`else
              state     <= ITER;
`endif
            end
          end
        end
        ITER: begin
          if (hh_done) state <= FINAL;
        end
        FINAL: begin
          if (!fin_phase) begin
            hi_raw    <= hi_sum;
            fin_phase <= 1'b1;
          end else begin
            result_q  <= hi_final;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            fin_phase <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_qsys_cpu_mul_result.sv
// Directed bench for the W-stage multiply result block: MUL, MULX* ops, back-to-back, hold-while-busy, reset abort.
// Latency: expected high-word latency follows RADIX and NIOS2_MUL_HH_DSP_EN.
// Backpressure: requests are held until M_ready, as the M stage would.
`timescale 1ns/1ps
module tb_nios2_qsys_cpu_mul_result;
  import nios2_qsys_cpu_mul_pkg::*;

  parameter int RADIX = 1;
`ifdef NIOS2_MUL_HH_DSP_EN
  localparam int HI_LAT = 2;
`else
  localparam int HI_LAT = 16 / RADIX + 2;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  nios2_qsys_cpu_mul_result_if mif ();

  nios2_qsys_cpu_mul_result #(.RADIX(RADIX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pp(input logic [15:0] x, input logic [15:0] y);
    return {16'b0, x} * {16'b0, y};
  endfunction

  // Present an operation with the partial products a multiply cell would deliver.
  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.M_op          = op;
    mif.M_src1        = a;
    mif.M_src2        = b;
    mif.M_mul_cell_p1 = pp(a[15:0], b[15:0]);
    mif.M_mul_cell_p2 = pp(a[15:0], b[31:16]);
    mif.M_mul_cell_p3 = pp(a[31:16], b[15:0]);
    mif.M_valid       = 1'b1;
  endtask

  // Offer an op, hold until accepted, return #1 after the acceptance edge with M_valid dropped.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int waited;
    drive(op, a, b);
    waited = 0;
    while (mif.M_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 40) begin
      checks++; errors++;
      $display("FAIL issue_timeout: M_ready never rose, got %b want 1", mif.M_ready);
    end
    @(posedge clk); #1;
    mif.M_valid = 1'b0;
  endtask

  // Count cycles to the next strobe, plus cycles seen with M_ready low and busy high.
  task automatic wait_result(output int lat, output logic [31:0] res, output int rdy_low, output int busy_hi);
    lat     = -1;
    res     = '0;
    rdy_low = (mif.M_ready === 1'b0) ? 1 : 0;
    busy_hi = (mif.W_mul_busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mif.W_mul_valid === 1'b1) begin
        lat = k;
        res = mif.W_mul_result;
        break;
      end
      if (mif.M_ready === 1'b0) rdy_low++;
      if (mif.W_mul_busy === 1'b1) busy_hi++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mif.M_valid = 1'b0; mif.M_op = '0; mif.M_src1 = '0; mif.M_src2 = '0;
    mif.M_mul_cell_p1 = '0; mif.M_mul_cell_p2 = '0; mif.M_mul_cell_p3 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mif.M_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mif.M_ready); end
    checks++; if (mif.W_mul_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mif.W_mul_valid); end
    checks++; if (mif.W_mul_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", mif.W_mul_result); end
    checks++; if (mif.W_mul_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mif.W_mul_busy); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat, rl, bh; logic [31:0] res;
    issue(MUL_OP_MUL, 32'h00010003, 32'h00020005);
    checks++; if (mif.M_ready !== 1'b1) begin errors++; $display("FAIL mul_ready: got %b want 1", mif.M_ready); end
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mul_latency: got %0d want 1", lat); end
    checks++; if (res !== 32'h000B000F) begin errors++; $display("FAIL mul_result: got %h want 000b000f", res); end
    checks++; if (rl !== 0) begin errors++; $display("FAIL mul_ready_low: got %0d want 0", rl); end
  endtask

  task automatic test_all_ones();
    int lat, rl, bh; logic [31:0] res;
    issue(MUL_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== 1 || res !== 32'h00000001) begin errors++; $display("FAIL ones_mul: got lat %0d res %h want lat 1 res 00000001", lat, res); end
    issue(MUL_OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== HI_LAT) begin errors++; $display("FAIL ones_mulxuu_latency: got %0d want %0d", lat, HI_LAT); end
    checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL ones_mulxuu_result: got %h want fffffffe", res); end
    checks++; if (rl !== HI_LAT) begin errors++; $display("FAIL ones_ready_low: got %0d want %0d", rl, HI_LAT); end
    checks++; if (bh !== HI_LAT) begin errors++; $display("FAIL ones_busy_cycles: got %0d want %0d", bh, HI_LAT); end
    checks++; if (mif.W_mul_busy !== 1'b0) begin errors++; $display("FAIL ones_busy_end: got %b want 0", mif.W_mul_busy); end
    issue(MUL_OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== HI_LAT || res !== 32'h00000000) begin errors++; $display("FAIL ones_mulxss: got lat %0d res %h want lat %0d res 00000000", lat, res, HI_LAT); end
    @(posedge clk); #1;
    checks++; if (mif.W_mul_valid !== 1'b0 || mif.W_mul_result !== 32'h0) begin errors++; $display("FAIL ones_hold: got valid %b res %h want 0 00000000", mif.W_mul_valid, mif.W_mul_result); end
  endtask

  task automatic test_signed();
    int lat, rl, bh; logic [31:0] res;
    issue(MUL_OP_MULXSS, 32'h80000000, 32'h80000000);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== HI_LAT || res !== 32'h40000000) begin errors++; $display("FAIL mulxss_min: got lat %0d res %h want lat %0d res 40000000", lat, res, HI_LAT); end
    issue(MUL_OP_MULXSU, 32'hFFFFFFFF, 32'h80000000);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== HI_LAT || res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulxsu: got lat %0d res %h want lat %0d res ffffffff", lat, res, HI_LAT); end
    issue(MUL_OP_MULXUU, 32'h12345678, 32'h9ABCDEF0);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== HI_LAT || res !== 32'h0B00EA4E) begin errors++; $display("FAIL mulxuu_mixed: got lat %0d res %h want lat %0d res 0b00ea4e", lat, res, HI_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] exp [4];
    a[0] = 32'h00000001; b[0] = 32'h00000001; exp[0] = 32'h00000001;
    a[1] = 32'h00000002; b[1] = 32'h00000003; exp[1] = 32'h00000006;
    a[2] = 32'h12345678; b[2] = 32'h00000010; exp[2] = 32'h23456780;
    a[3] = 32'hFFFFFFFF; b[3] = 32'h00000002; exp[3] = 32'hFFFFFFFE;
    drive(MUL_OP_MUL, a[0], b[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        checks++;
        if (mif.W_mul_valid !== 1'b1 || mif.W_mul_result !== exp[i-1]) begin
          errors++; $display("FAIL b2b_%0d: got valid %b res %h want 1 %h", i - 1, mif.W_mul_valid, mif.W_mul_result, exp[i-1]);
        end
      end
      if (i < 3) drive(MUL_OP_MUL, a[i+1], b[i+1]);
      else mif.M_valid = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (mif.W_mul_valid !== 1'b1 || mif.W_mul_result !== exp[3]) begin
      errors++; $display("FAIL b2b_3: got valid %b res %h want 1 %h", mif.W_mul_valid, mif.W_mul_result, exp[3]);
    end
  endtask

  task automatic test_hold_during_busy();
    int lat, rl, bh; logic [31:0] res;
    issue(MUL_OP_MULXUU, 32'h00020000, 32'h00030000);
    drive(MUL_OP_MUL, 32'h00000005, 32'h00000007);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== HI_LAT || res !== 32'h00000006) begin errors++; $display("FAIL hold_first: got lat %0d res %h want lat %0d res 00000006", lat, res, HI_LAT); end
    @(posedge clk); #1;
    mif.M_valid = 1'b0;
    checks++; if (mif.W_mul_valid !== 1'b0) begin errors++; $display("FAIL hold_gap: got valid %b want 0", mif.W_mul_valid); end
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== 1 || res !== 32'h00000023) begin errors++; $display("FAIL hold_second: got lat %0d res %h want lat 1 res 00000023", lat, res); end
  endtask

  task automatic test_reset_mid();
    int lat, rl, bh, strobes; logic [31:0] res;
    issue(MUL_OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mif.W_mul_valid !== 1'b0 || mif.W_mul_result !== 32'h0 || mif.W_mul_busy !== 1'b0 || mif.M_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs: got valid %b res %h busy %b ready %b want 0 00000000 0 1",
                         mif.W_mul_valid, mif.W_mul_result, mif.W_mul_busy, mif.M_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (mif.W_mul_valid === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL midreset_strobes: got %0d want 0", strobes); end
    checks++; if (mif.M_ready !== 1'b1 || mif.W_mul_result !== 32'h0) begin errors++; $display("FAIL midreset_idle: got ready %b res %h want 1 00000000", mif.M_ready, mif.W_mul_result); end
    issue(MUL_OP_MUL, 32'h00000002, 32'h00000003);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== 1 || res !== 32'h00000006) begin errors++; $display("FAIL midreset_mul: got lat %0d res %h want lat 1 res 00000006", lat, res); end
    issue(MUL_OP_MULXUU, 32'h00020000, 32'h00030000);
    wait_result(lat, res, rl, bh);
    checks++; if (lat !== HI_LAT || res !== 32'h00000006) begin errors++; $display("FAIL midreset_hi: got lat %0d res %h want lat %0d res 00000006", lat, res, HI_LAT); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul();
    test_all_ones();
    test_signed();
    test_back_to_back();
    test_hold_during_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
